// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns one raw pushbutton pin into a clean debounced level plus
//   single-cycle press, release and hold strobes. The raw pin is
//   synchronised through two flops and then a four-state debounce FSM
//   decides when a change has been stable long enough to accept.
//
//   `release` is a reserved word in SystemVerilog, so the release strobe
//   is exposed as release_pulse.
//
//   debug_state mirrors the FSM state register for observation.
//
//   All strobes use the same rule: a pulse is high for exactly one clock,
//   is registered, and has no handshake. Consumers must sample it every
//   cycle.

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 0,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       level,
  output logic       press,
  output logic       release_pulse,
  output logic       hold,
  output logic [1:0] debug_state
);

  // Counter widths. The hold counter keeps at least one bit so the design
  // still elaborates when hold is disabled.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_CYCLES - 1);

  // Pin value that means "pressed".
  localparam logic PRESSED_POL  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic RELEASED_POL = ~PRESSED_POL;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Synchroniser flops.
  logic s1;
  logic s2;
  logic p;

  // FSM state and counters.
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_next;

  // Next values of the registered outputs.
  logic level_next;
  logic press_next;
  logic release_next;
  logic hold_next;

  // Two-flop synchroniser. It resets to the released polarity, so a button
  // held through reset is seen as a fresh press and is re-debounced.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= RELEASED_POL;
      s2 <= RELEASED_POL;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  assign p = (s2 == PRESSED_POL);

  // State, counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= CNT_ZERO;
      hold_cnt      <= HOLD_ZERO;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      hold          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      hold_cnt      <= hold_cnt_next;
      level         <= level_next;
      press         <= press_next;
      release_pulse <= release_next;
      hold          <= hold_next;
    end
  end

  // Next-state and output decode for the debounce FSM.
  // cnt counts consecutive stable samples of the candidate level. It starts
  // at 1 on the sample that first disagrees with the accepted level, so the
  // change is accepted on the DEBOUNCE_CYCLES-th stable sample.
  // hold_cnt only advances while the FSM is in PRESSED and saturates at
  // HOLD_CYCLES, which limits hold to one pulse per press.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    hold_cnt_next = hold_cnt;
    level_next    = level;
    press_next    = 1'b0;
    release_next  = 1'b0;
    hold_next     = 1'b0;

    unique case (state)
      IDLE: begin
        level_next = 1'b0;
        if (p) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!p) begin
          // Bounce: go back without emitting a pulse.
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next    = PRESSED;
          cnt_next      = CNT_ZERO;
          hold_cnt_next = HOLD_ZERO;
          level_next    = 1'b1;
          press_next    = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      PRESSED: begin
        level_next = 1'b1;
        if (!p) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end else if ((HOLD_CYCLES != 0) && (hold_cnt != HOLD_LAST)) begin
          hold_cnt_next = hold_cnt + HOLD_ONE;
          if (hold_cnt == HOLD_PRE) begin
            hold_next = 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        // level stays high until the release is accepted. hold_cnt is
        // frozen here and resumes if the release turns out to be a bounce.
        if (p) begin
          state_next = PRESSED;
          cnt_next   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          cnt_next     = CNT_ZERO;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
        level_next = 1'b0;
      end
    endcase
  end

  assign debug_state = state;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner.
//   dut_a: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, active-low pin.
//   dut_b: DEBOUNCE_CYCLES=4, HOLD_CYCLES=0,  active-high pin.
// Inputs change 1 ns after a rising edge. Outputs are checked at the same
// point, so "after edge i" means "observed after the i-th tick following
// the stimulus change". Each comparison packs {level, press, release, hold}.

module tb_button_conditioner;

  // Clock and reset.
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // DUT A signals.
  logic       btn_a;
  logic       level_a, press_a, release_a, hold_a;
  logic [1:0] state_a;

  // DUT B signals.
  logic       btn_b;
  logic       level_b, press_b, release_b, hold_b;
  logic [1:0] state_b;

  int checks;
  int passed;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1)
  ) dut_a (
    .clock(clock), .reset(reset), .btn_raw(btn_a),
    .level(level_a), .press(press_a), .release_pulse(release_a),
    .hold(hold_a), .debug_state(state_a)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(0), .ACTIVE_LOW(0)
  ) dut_b (
    .clock(clock), .reset(reset), .btn_raw(btn_b),
    .level(level_b), .press(press_b), .release_pulse(release_b),
    .hold(hold_b), .debug_state(state_b)
  );

  // Advance one rising edge, then settle for 1 ns.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1;
    btn_a = 1'b1;
    btn_b = 1'b0;
    tick(); tick(); tick();
    got = {level_a, press_a, release_a, hold_a};
    checks++;
    if (got !== 4'b0000) $display("FAIL reset_a_outputs got %b want 0000", got);
    else passed++;
    got = {level_b, press_b, release_b, hold_b};
    checks++;
    if (got !== 4'b0000) $display("FAIL reset_b_outputs got %b want 0000", got);
    else passed++;
    checks++;
    if (state_a !== 2'd0) $display("FAIL reset_a_state got %0d want 0", state_a);
    else passed++;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      got = {level_a, press_a, release_a, hold_a};
      checks++;
      if (got !== 4'b0000) $display("FAIL idle_after_reset edge %0d got %b want 0000", i, got);
      else passed++;
    end
  endtask

  // The pin falls before edge 1 and stays low. Press is expected at edge 6.
  // The button is then released and the release is expected at edge 6.
  task automatic test_single_press();
    logic [3:0] got, exp;
    btn_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {level_a, press_a, release_a, hold_a};
      exp = {(i >= 6), (i == 6), 1'b0, 1'b0};
      checks++;
      if (got !== exp) $display("FAIL single_press edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
    btn_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {level_a, press_a, release_a, hold_a};
      exp = {(i < 6), 1'b0, (i == 6), 1'b0};
      checks++;
      if (got !== exp) $display("FAIL single_release edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
  endtask

  // Pin is low before edges 1-2, high before edge 3, and low from edge 4
  // onwards. The final fall is first sampled at edge 4, so press comes at 9.
  task automatic test_bounce_press();
    logic [3:0] got, exp;
    for (int i = 1; i <= 9; i++) begin
      btn_a = (i == 3);
      tick();
      got = {level_a, press_a, release_a, hold_a};
      exp = {(i >= 9), (i == 9), 1'b0, 1'b0};
      checks++;
      if (got !== exp) $display("FAIL bounce_press edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
  endtask

  // The press was accepted on the last tick of the previous task. Hold is
  // expected exactly 10 clocks later, with no further pulse afterwards.
  task automatic test_hold();
    logic [3:0] got, exp;
    for (int i = 1; i <= 50; i++) begin
      tick();
      got = {level_a, press_a, release_a, hold_a};
      exp = {1'b1, 1'b0, 1'b0, (i == 10)};
      checks++;
      if (got !== exp) $display("FAIL hold edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
  endtask

  // Pin is high before edge 1, low before edge 2 (bounce), and high from
  // edge 3. The final rise is sampled at edge 3, so release comes at edge 8.
  task automatic test_release_bounce();
    logic [3:0] got, exp;
    for (int i = 1; i <= 10; i++) begin
      btn_a = (i != 2);
      tick();
      got = {level_a, press_a, release_a, hold_a};
      exp = {(i < 8), 1'b0, (i == 8), 1'b0};
      checks++;
      if (got !== exp) $display("FAIL release_bounce edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
  endtask

  // Press, then reset for one clock while PRESSED. Outputs are expected to
  // clear with no release pulse. With the pin still low, a new press is
  // expected 6 edges after the reset edge.
  task automatic test_reset_mid();
    logic [3:0] got, exp;
    btn_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {level_a, press_a, release_a, hold_a};
      exp = {(i >= 6), (i == 6), 1'b0, 1'b0};
      checks++;
      if (got !== exp) $display("FAIL pre_reset_press edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = {level_a, press_a, release_a, hold_a};
    checks++;
    if (got !== 4'b0000) $display("FAIL mid_reset_clear got %b want 0000", got);
    else passed++;
    for (int j = 1; j <= 8; j++) begin
      tick();
      got = {level_a, press_a, release_a, hold_a};
      exp = {(j >= 6), (j == 6), 1'b0, 1'b0};
      checks++;
      if (got !== exp) $display("FAIL post_reset_press edge %0d got %b want %b", j, got, exp);
      else passed++;
    end
    btn_a = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    got = {level_a, press_a, release_a, hold_a};
    checks++;
    if (got !== 4'b0000) $display("FAIL post_reset_idle got %b want 0000", got);
    else passed++;
  endtask

  // Active-high instance with hold disabled. The timing matches
  // test_single_press, and hold never asserts.
  task automatic test_active_high();
    logic [3:0] got, exp;
    btn_b = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      got = {level_b, press_b, release_b, hold_b};
      exp = {(i >= 6), (i == 6), 1'b0, 1'b0};
      checks++;
      if (got !== exp) $display("FAIL active_high_press edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
    btn_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {level_b, press_b, release_b, hold_b};
      exp = {(i < 6), 1'b0, (i == 6), 1'b0};
      checks++;
      if (got !== exp) $display("FAIL active_high_release edge %0d got %b want %b", i, got, exp);
      else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    btn_a  = 1'b1;
    btn_b  = 1'b0;
    test_reset();
    test_single_press();
    test_bounce_press();
    test_hold();
    test_release_bounce();
    test_reset_mid();
    test_active_high();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
